eim_burst_slave: RTL
====================

Name: eim_burst_slave

Overview:
Parametrised successor to the fixed 16-bit EIM front end. It runs in the bus_clk domain on EIM pins already registered by the pad logic. It decodes multiplexed address/data bursts from one chip select and drives a synchronous bus with auto-incrementing addresses. Unlike the previous generation, it supports a configurable read latency, back-pressure from the bus side through an actively driven EIM wait, burst-length limiting and optional address wrap.

Parameters:
DATA_W, 16, EIM data/bus data width in bits (16 or 32)
ADDR_HI_W, 3, upper address bits sampled from eim_a_hi
RD_LATENCY, 1, bus_clk cycles from bus read strobe to valid bus_data_rd (1..4)
MAX_BURST, 32, maximum beats per burst; beats beyond it are errors
WRAP_BEATS, 0, 0 = linear increment; power of two N = address wraps within an N-beat aligned window

Ports:
bus_clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high
eim_cs_n  in  1  registered chip select, active low
eim_lba_n  in  1  registered address-valid strobe, active low
eim_rw  in  1  1 = CPU read, 0 = CPU write
eim_oe_n  in  1  registered output enable, active low
eim_a_hi  in  ADDR_HI_W  registered upper address
eim_din  in  DATA_W  registered EIM data/low address
eim_dout  out  DATA_W  read data to output pad registers
eim_dout_oe  out  1  drive enable for DA pads
eim_wait_n  out  1  EIM wait, low = CPU must stall
bus_addr  out  ADDR_HI_W+DATA_W  byte address of current beat
bus_sel  out  1  one-cycle beat strobe
bus_wr  out  1  1 = write beat, 0 = read beat; valid with bus_sel
bus_data_wr  out  DATA_W  write data; valid with bus_sel & bus_wr
bus_data_rd  in  DATA_W  read data, RD_LATENCY cycles after read bus_sel
bus_ready  in  1  bus side can accept a beat this cycle
burst_err  out  1  sticky: overlong burst or CS drop mid-read; cleared by reset only

Behaviour:
- Reset values:
  - eim_dout = 0, eim_dout_oe = 0, eim_wait_n = 1, bus_sel = 0, bus_wr = 0.
  - bus_addr = 0, bus_data_wr = 0, burst_err = 0.
  - FSM state = IDLE, beat counter = 0.
- States:
  - IDLE: waits for eim_cs_n=0 and eim_lba_n=0; then latches the base address {eim_a_hi, eim_din} and goes to ADDR.
  - ADDR: one cycle. bus_addr = base. Goes to WR if eim_rw=0, otherwise RD_REQ.
  - WR: each cycle with eim_cs_n=0, eim_lba_n=1 and bus_ready=1:
    - bus_sel=1, bus_wr=1, bus_data_wr=eim_din;
    - the address advances by DATA_W/8 after the beat; beat counter +1.
    - If bus_ready=0 while CS is low: eim_wait_n=0, no beat issued, data held until bus_ready returns (CPU holds DA while waited).
  - RD_REQ: issues bus_sel=1, bus_wr=0 when bus_ready=1, then goes to RD_WAIT. eim_wait_n=0 from ADDR until read data is presented.
  - RD_WAIT: counts RD_LATENCY cycles, then registers bus_data_rd into eim_dout and goes to RD_DATA.
  - RD_DATA: eim_wait_n=1 for one cycle; the CPU samples. Address advances. Returns to RD_REQ if CS is still low, otherwise IDLE.
  - A new eim_lba_n=0 while CS is low restarts from ADDR with the new address (back-to-back bursts, no IDLE cycle).
- eim_dout_oe = !eim_oe_n & eim_lba_n & eim_rw & (state in RD_REQ/RD_WAIT/RD_DATA).
- Read throughput: one beat per RD_LATENCY+2 cycles.
- Wrap: with WRAP_BEATS=N, the low log2(N*DATA_W/8) address bits increment modulo the window; upper bits are frozen. With WRAP_BEATS=0, increment is full-width modulo 2^(ADDR_HI_W+DATA_W).
- Boundary conditions:
  - Beat counter saturates at MAX_BURST. A further beat sets burst_err, the beat is suppressed (no bus_sel) and eim_wait_n is held 1.
  - eim_cs_n rising in any state forces IDLE next cycle and clears eim_wait_n to 1. An in-flight read's bus_data_rd is discarded. If the rise occurs in RD_REQ/RD_WAIT, burst_err is set.
  - Simultaneous eim_lba_n=0 and eim_cs_n rising: CS wins; go to IDLE.
  - Reset asserted mid-burst: all outputs return to reset values on the next edge; no bus_sel is issued in that cycle.

Test Plan:
- Single write: LBA with a_hi=3'b001, din=16'h0100; then one data beat 16'hBEEF, bus_ready=1 -> one bus_sel with bus_wr=1, bus_addr=19'h10100, bus_data_wr=16'hBEEF; eim_wait_n stays 1.
- 4-beat write burst from 0x0000 with bus_ready low for 2 cycles on beat 2 -> eim_wait_n=0 for exactly those 2 cycles; addresses 0,2,4,6 each strobed once; no duplicate or dropped data.
- Read, RD_LATENCY=3, base 0x0040, bus_data_rd = address -> eim_dout=16'h0040 five cycles after ADDR; eim_wait_n low until then; second beat gives 16'h0042.
- WRAP_BEATS=4, DATA_W=16, burst of 6 writes starting at 0x0006 -> bus_addr sequence 6,0,2,4,6,0.
- MAX_BURST=4, 5-beat write -> 4 bus_sel pulses, burst_err=1 at the fifth beat, persists after CS high.
- CS raised during RD_WAIT, then reset pulsed mid-burst -> state IDLE, eim_wait_n=1, burst_err=1 then 0 after reset, no bus_sel during the reset cycle.

Source files
------------

// File: rtl/eim_burst_slave.sv
// EIM multiplexed address/data burst slave bridging to a synchronous bus.
// Adds read latency, bus back-pressure via EIM wait, burst limit and wrap.
module eim_burst_slave #(
  parameter int DATA_W     = 16,
  parameter int ADDR_HI_W  = 3,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 32,
  parameter int WRAP_BEATS = 0
) (
  input  logic                        bus_clk,
  input  logic                        reset,
  input  logic                        eim_cs_n,
  input  logic                        eim_lba_n,
  input  logic                        eim_rw,
  input  logic                        eim_oe_n,
  input  logic [ADDR_HI_W-1:0]        eim_a_hi,
  input  logic [DATA_W-1:0]           eim_din,
  output logic [DATA_W-1:0]           eim_dout,
  output logic                        eim_dout_oe,
  output logic                        eim_wait_n,
  output logic [ADDR_HI_W+DATA_W-1:0] bus_addr,
  output logic                        bus_sel,
  output logic                        bus_wr,
  output logic [DATA_W-1:0]           bus_data_wr,
  input  logic [DATA_W-1:0]           bus_data_rd,
  input  logic                        bus_ready,
  output logic                        burst_err
);

  localparam int AW   = ADDR_HI_W + DATA_W;
  localparam int STEP = DATA_W / 8;
  localparam int CW   = $clog2(MAX_BURST + 1);
  localparam int LW   = $clog2(RD_LATENCY + 1);
  // Bits outside the wrap window stay frozen while the burst advances.
  localparam logic [AW-1:0] KEEP =
    (WRAP_BEATS == 0) ? '0 : ~AW'(WRAP_BEATS * STEP - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WR, RD_REQ, RD_WAIT, RD_DATA
  } state_t;

  state_t        state;
  logic [AW-1:0] cur;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lat;
  logic [AW-1:0] base;
  logic [AW-1:0] inc;
  logic [AW-1:0] nxt;
  logic          full;

  assign base = {eim_a_hi, eim_din};
  assign inc  = cur + AW'(STEP);
  assign nxt  = (cur & KEEP) | (inc & ~KEEP);
  assign full = (cnt == CW'(MAX_BURST));

  assign eim_dout_oe = !eim_oe_n && eim_lba_n && eim_rw &&
    (state == RD_REQ || state == RD_WAIT || state == RD_DATA);

  always_ff @(posedge bus_clk) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      cnt         <= '0;
      lat         <= '0;
      eim_dout    <= '0;
      eim_wait_n  <= 1'b1;
      bus_addr    <= '0;
      bus_sel     <= 1'b0;
      bus_wr      <= 1'b0;
      bus_data_wr <= '0;
      burst_err   <= 1'b0;
    end else begin
      bus_sel <= 1'b0;
      if (state != IDLE && eim_cs_n) begin
        // CS drop aborts everything; an in-flight read is dropped.
        state      <= IDLE;
        cnt        <= '0;
        eim_wait_n <= 1'b1;
        if (state == RD_REQ || state == RD_WAIT)
          burst_err <= 1'b1;
      end else if (!eim_cs_n && !eim_lba_n) begin
        state      <= ADDR;
        cur        <= base;
        bus_addr   <= base;
        cnt        <= '0;
        eim_wait_n <= !eim_rw;
      end else begin
        unique case (state)
          IDLE: ;
          ADDR: begin
            state      <= eim_rw ? RD_REQ : WR;
            eim_wait_n <= !eim_rw;
          end
          WR: begin
            if (full) begin
              burst_err  <= 1'b1;
              eim_wait_n <= 1'b1;
            end else if (bus_ready) begin
              bus_sel     <= 1'b1;
              bus_wr      <= 1'b1;
              bus_data_wr <= eim_din;
              bus_addr    <= cur;
              cur         <= nxt;
              cnt         <= cnt + CW'(1);
              eim_wait_n  <= 1'b1;
            end else begin
              eim_wait_n <= 1'b0;
            end
          end
          RD_REQ: begin
            if (full) begin
              burst_err  <= 1'b1;
              eim_wait_n <= 1'b1;
            end else if (bus_ready) begin
              bus_sel  <= 1'b1;
              bus_wr   <= 1'b0;
              bus_addr <= cur;
              cur      <= nxt;
              cnt      <= cnt + CW'(1);
              lat      <= '0;
              state    <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (lat == LW'(RD_LATENCY - 1)) begin
              eim_dout   <= bus_data_rd;
              eim_wait_n <= 1'b1;
              state      <= RD_DATA;
            end else begin
              lat <= lat + LW'(1);
            end
          end
          RD_DATA: begin
            state      <= RD_REQ;
            eim_wait_n <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
